// File: rtl/fir_seq_if.sv
// Sample/result handshake and coefficient-write port bundle for fir_seq.
// master drives samples and taps; slave is the filter.
interface fir_seq_if #(
    parameter int N = 10,
    parameter int W = 16
);
    localparam int AW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_seq.sv
// Sequential N-tap FIR: one multiply-accumulate per cycle, then a rounded and
// saturated result held until the consumer takes it.
module fir_seq #(
    parameter int N     = 10,
    parameter int W     = 16,
    parameter int SHIFT = 0
) (
    input logic      clock,
    input logic      reset,
    fir_seq_if.slave bus
);
    localparam int AW   = $clog2(N);
    localparam int ACCW = 2 * W + AW;
    localparam int RS   = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [ACCW:0]        ONE      = {{ACCW{1'b0}}, 1'b1};
    localparam logic signed [ACCW:0] RND      = (SHIFT > 0) ? (ONE << RS) : '0;
    localparam logic signed [ACCW:0] SAT_MAX  = {{(ACCW - W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ACCW:0] SAT_MIN  = {{(ACCW - W + 2){1'b1}}, {(W - 1){1'b0}}};
    localparam logic [AW-1:0]        IDX_LAST = AW'(N - 1);
    localparam logic [AW:0]          NUM_TAPS = (AW + 1)'(N);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_t;

    state_t                 r_state;
    logic signed [W-1:0]    r_x [N];
    logic signed [W-1:0]    r_h [N];
    logic signed [ACCW-1:0] r_acc;
    logic [AW-1:0]          r_idx;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic signed [W-1:0]    r_out_data;

    logic signed [2*W-1:0]  w_prod;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW:0]   w_rnd;
    logic signed [ACCW:0]   w_shf;
    logic signed [W-1:0]    w_sat;
    logic                   w_addr_ok;

    always_comb begin
        w_prod    = (2 * W)'(r_x[r_idx]) * (2 * W)'(r_h[r_idx]);
        w_sum     = r_acc + {{AW{w_prod[2*W-1]}}, w_prod};
        // One guard bit so the rounding constant can never wrap the sum.
        w_rnd     = {w_sum[ACCW-1], w_sum} + RND;
        w_shf     = w_rnd >>> SHIFT;
        w_sat     = w_shf[W-1:0];
        if (w_shf > SAT_MAX) begin
            w_sat = SAT_MAX[W-1:0];
        end else if (w_shf < SAT_MIN) begin
            w_sat = SAT_MIN[W-1:0];
        end
        w_addr_ok = {1'b0, bus.coef_addr} < NUM_TAPS;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
                r_h[k] <= '0;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.coef_we && w_addr_ok) begin
                        r_h[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.in_valid) begin
                        for (int k = N - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0]     <= bus.in_data;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StMac;
                    end
                end
                StMac: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_out_data  <= w_sat;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_fir_seq.sv
// Directed bench for fir_seq: a 4-tap unshifted instance and a 3-tap SHIFT=2
// instance, with hand-computed expected outputs.
module tb_fir_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   lat;
    int   seen;

    always #5 clock = ~clock;

    fir_seq_if #(.N(4), .W(16)) a ();
    fir_seq_if #(.N(3), .W(16)) b ();

    fir_seq #(.N(4), .W(16), .SHIFT(0)) u_a (.clock(clock), .reset(reset), .bus(a.slave));
    fir_seq #(.N(3), .W(16), .SHIFT(2)) u_b (.clock(clock), .reset(reset), .bus(b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_all(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic coef_a(input logic [1:0] addr, input logic [15:0] data);
        a.coef_we = 1'b1; a.coef_addr = addr; a.coef_data = data;
        @(negedge clock);
        a.coef_we = 1'b0;
    endtask

    task automatic taps_a(input logic [15:0] h0, h1, h2, h3);
        coef_a(2'd0, h0); coef_a(2'd1, h1); coef_a(2'd2, h2); coef_a(2'd3, h3);
    endtask

    task automatic accept_a(input logic [15:0] s, input string tag);
        int t = 0;
        while (!a.in_ready && t < 40) begin @(negedge clock); t++; end
        chk({tag, "_rdy"}, 32'(a.in_ready), 32'd1);
        a.in_valid = 1'b1; a.in_data = s;
        @(negedge clock);
        a.in_valid = 1'b0;
    endtask

    task automatic wait_out_a(output int l);
        l = 0;
        while (!a.out_valid && l < 40) begin @(negedge clock); l++; end
    endtask

    task automatic send_a(input logic [15:0] s, input logic [15:0] exp, input string tag);
        int l;
        accept_a(s, tag);
        wait_out_a(l);
        chk({tag, "_lat"}, 32'(l), 32'd4);
        chk({tag, "_dat"}, 32'(a.out_data), 32'(exp));
        @(negedge clock);
        chk({tag, "_done"}, 32'(a.out_valid), 32'd0);
    endtask

    task automatic coef_b(input logic [1:0] addr, input logic [15:0] data);
        b.coef_we = 1'b1; b.coef_addr = addr; b.coef_data = data;
        @(negedge clock);
        b.coef_we = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] s, input logic [15:0] exp, input string tag);
        int t = 0;
        while (!b.in_ready && t < 40) begin @(negedge clock); t++; end
        b.in_valid = 1'b1; b.in_data = s;
        @(negedge clock);
        b.in_valid = 1'b0;
        t = 0;
        while (!b.out_valid && t < 40) begin @(negedge clock); t++; end
        chk({tag, "_lat"}, 32'(t), 32'd3);
        chk({tag, "_dat"}, 32'(b.out_data), 32'(exp));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1;
        a.coef_we = 1'b0; a.coef_addr = '0; a.coef_data = '0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
        b.coef_we = 1'b0; b.coef_addr = '0; b.coef_data = '0;

        // Reset and idle behaviour
        reset_all(2);
        chk("rst_ov", 32'(a.out_valid), 32'd0);
        chk("rst_od", 32'(a.out_data), 32'd0);
        chk("rst_rdy", 32'(a.in_ready), 32'd1);
        @(negedge clock);
        chk("idle_rdy", 32'(a.in_ready), 32'd1);
        send_a(16'd5, 16'd0, "deftap");

        // Rounding and out-of-range tap address on the shifted instance
        coef_b(2'd0, 16'd1);
        coef_b(2'd3, 16'd50);
        send_b(16'd6, 16'd2, "rnd6");
        send_b(16'hFFFA, 16'hFFFF, "rndneg");

        // Impulse response
        reset_all(1);
        taps_a(16'd1, 16'd2, 16'd3, 16'd4);
        send_a(16'd1, 16'd1, "imp0");
        send_a(16'd0, 16'd2, "imp1");
        send_a(16'd0, 16'd3, "imp2");
        send_a(16'd0, 16'd4, "imp3");
        send_a(16'd0, 16'd0, "imp4");

        // Step response
        reset_all(1);
        taps_a(16'd1, 16'd1, 16'd1, 16'd1);
        send_a(16'd10, 16'd10, "step0");
        send_a(16'd10, 16'd20, "step1");
        send_a(16'd10, 16'd30, "step2");
        send_a(16'd10, 16'd40, "step3");
        send_a(16'd10, 16'd40, "step4");

        // Saturation in both directions
        reset_all(1);
        taps_a(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        send_a(16'h7FFF, 16'h7FFF, "satpos");
        reset_all(1);
        taps_a(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        send_a(16'h8000, 16'h8000, "satneg");

        // Backpressure: result held, input blocked, stray in_valid ignored
        reset_all(1);
        taps_a(16'd1, 16'd2, 16'd3, 16'd4);
        a.out_ready = 1'b0;
        accept_a(16'd3, "bp");
        wait_out_a(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            a.in_valid = 1'b1; a.in_data = 16'd99;
            @(negedge clock);
            chk("bp_hold", 32'(a.out_data), 32'd3);
            chk("bp_ov", 32'(a.out_valid), 32'd1);
            chk("bp_rdy", 32'(a.in_ready), 32'd0);
        end
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clock);
        chk("bp_xfer", 32'(a.out_valid), 32'd0);
        chk("bp_idle", 32'(a.in_ready), 32'd1);
        send_a(16'd0, 16'd6, "bp_next");

        // Coefficient writes during MAC and OUT must not land
        a.out_ready = 1'b0;
        accept_a(16'd1, "cm");
        a.coef_we = 1'b1; a.coef_addr = 2'd0; a.coef_data = 16'd100;
        @(negedge clock);
        @(negedge clock);
        a.coef_we = 1'b0;
        wait_out_a(lat);
        chk("cm_lat", 32'(lat), 32'd2);
        chk("cm_dat", 32'(a.out_data), 32'd10);
        a.coef_we = 1'b1; a.coef_addr = 2'd1; a.coef_data = 16'd100;
        @(negedge clock);
        @(negedge clock);
        a.coef_we = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clock);
        chk("cm_xfer", 32'(a.out_valid), 32'd0);
        send_a(16'd0, 16'd14, "cm_out");

        // Reset in the middle of a MAC pass
        accept_a(16'd7, "rm");
        @(negedge clock);
        reset_all(1);
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (a.out_valid) seen++;
        end
        chk("rm_ov", 32'(seen), 32'd0);
        chk("rm_od", 32'(a.out_data), 32'd0);
        chk("rm_rdy", 32'(a.in_ready), 32'd1);
        taps_a(16'd1, 16'd1, 16'd1, 16'd1);
        send_a(16'd0, 16'd0, "rm_x");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
